// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_pkg
//  Description : Shared constants and types for the IO bus master and its
//                address decoder: bus widths, ctrl bit positions, size codes,
//                peripheral window, default wait counts and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_CTRL_W = 4;

  // ctrl bit positions
  localparam int CTRL_RD       = 0;
  localparam int CTRL_WR       = 1;
  localparam int CTRL_SIZE_LSB = 2;

  // access size encodings
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // Peripheral window: addr[31:12] equal to this base selects the device
  // space, where only the listed addr[7:4] nibbles are populated.
  localparam logic [19:0] PERIPH_BASE     = 20'hFFFFF;
  localparam logic [15:0] DEV_NIBBLE_LIST = {4'h7, 4'h6, 4'h1, 4'h0};

  localparam int DEF_RAM_WAIT = 1;
  localparam int DEF_DEV_WAIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_DEV  = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  function automatic logic is_dev_nibble(input logic [3:0] nib);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (DEV_NIBBLE_LIST[i*4 +: 4] == nib) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_master_if
//  Description : CPU request/response handshake plus the bus address,
//                control and query lines of the IO bus master.
//                master modport : the bus master side
//                slave modport  : CPU + responder side
//  Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_master_if
  import io_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int CTRL_W = BUS_CTRL_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              BC;
  logic [ADDR_W-1:0] addr;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, BC, addr, ctrl
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, BC, addr, ctrl
  );

endinterface
`default_nettype wire

// File: rtl/io_bus_decode.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_decode
//  Description : Combinational address classifier. Must stay identical to
//                the responder-side routing.
//  Ports       : addr     - byte address
//                region   - RAM / DEV / NONE
//                mapped   - address hits RAM or a populated device slot
//                wait_cnt - strobe length in cycles for the region
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_decode
  import io_bus_pkg::*;
#(
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int RAM_WAIT = DEF_RAM_WAIT,
  parameter int DEV_WAIT = DEF_DEV_WAIT
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region,
  output logic              mapped,
  output logic [3:0]        wait_cnt
);

  // Only addr[31:12] and addr[7:4] take part in routing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[11:8], addr[3:0]};

  always_comb begin
    region   = REGION_NONE;
    mapped   = 1'b0;
    wait_cnt = 4'd0;
    if (addr[31:12] != PERIPH_BASE) begin
      region   = REGION_RAM;
      mapped   = 1'b1;
      wait_cnt = 4'(RAM_WAIT);
    end else if (is_dev_nibble(addr[7:4])) begin
      region   = REGION_DEV;
      mapped   = 1'b1;
      wait_cnt = 4'(DEV_WAIT);
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_master
//  Description : Single-outstanding CPU-to-IO bus master. Each request runs
//                IDLE -> SETUP -> ACCESS (wait-count strobe cycles) -> RESP,
//                or SETUP -> RESP directly for erroneous requests.
//  Ports       : clk, rst - clock and synchronous active-high reset
//                bus      - request/response handshake, BC, addr, ctrl
//                data     - tri-state bus data, driven only during writes
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int DATA_W   = BUS_DATA_W,
  parameter int CTRL_W   = BUS_CTRL_W,
  parameter int RAM_WAIT = DEF_RAM_WAIT,
  parameter int DEV_WAIT = DEF_DEV_WAIT
) (
  input  logic                 clk,
  input  logic                 rst,
  io_bus_master_if.master      bus,
  // Kept as a plain inout so the tri-state resolves on the board-level net.
  inout  wire  [DATA_W-1:0]    data
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                bc_q, bc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                data_oe_q, data_oe_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                err_q, err_d;
  logic [3:0]          cnt_q, cnt_d;

  region_e             dec_region;
  logic                dec_mapped;
  logic [3:0]          dec_wait;
  logic                req_err;
  logic [DATA_W-1:0]   wr_lanes;
  logic [DATA_W-1:0]   rd_shifted;
  logic [DATA_W-1:0]   rd_aligned;

  io_bus_decode #(
    .ADDR_W   (ADDR_W),
    .RAM_WAIT (RAM_WAIT),
    .DEV_WAIT (DEV_WAIT)
  ) u_decode (
    .addr     (bus.req_addr),
    .region   (dec_region),
    .mapped   (dec_mapped),
    .wait_cnt (dec_wait)
  );

  logic unused_region;
  assign unused_region = ^dec_region;

  // Request is rejected up front: unmapped, reserved size or misaligned.
  always_comb begin
    req_err = ~dec_mapped | (bus.req_size == SIZE_RSVD);
    if (bus.req_size == SIZE_HALF && bus.req_addr[0])          req_err = 1'b1;
    if (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b0) req_err = 1'b1;
  end

  // Write data is replicated into every lane so the responder can pick the
  // addressed lane without a shifter.
  always_comb begin
    case (bus.req_size)
      SIZE_BYTE: wr_lanes = {(DATA_W/8){bus.req_wdata[7:0]}};
      SIZE_HALF: wr_lanes = {(DATA_W/16){bus.req_wdata[15:0]}};
      default:   wr_lanes = bus.req_wdata;
    endcase
  end

  assign rd_shifted = data >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      SIZE_BYTE: rd_aligned = {{(DATA_W-8){1'b0}}, rd_shifted[7:0]};
      SIZE_HALF: rd_aligned = {{(DATA_W-16){1'b0}}, rd_shifted[15:0]};
      default:   rd_aligned = rd_shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    bc_d        = bc_q;
    addr_d      = addr_q;
    ctrl_d      = ctrl_q;
    data_oe_d   = data_oe_q;
    data_out_d  = data_out_q;
    we_d        = we_q;
    size_d      = size_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          err_d       = req_err;
          cnt_d       = dec_wait;
          bc_d        = 1'b1;
          addr_d      = bus.req_addr;
          ctrl_d      = '0;
          ctrl_d[CTRL_SIZE_LSB +: 2] = bus.req_size;
          data_oe_d   = bus.req_we & ~req_err;
          data_out_d  = wr_lanes;
        end
      end

      ST_SETUP: begin
        if (err_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          bc_d        = 1'b0;
          addr_d      = '0;
          ctrl_d      = '0;
          data_oe_d   = 1'b0;
          data_out_d  = '0;
        end else begin
          state_d = ST_ACCESS;
          if (we_q) ctrl_d[CTRL_WR] = 1'b1;
          else      ctrl_d[CTRL_RD] = 1'b1;
        end
      end

      ST_ACCESS: begin
        // cnt_q == 1 marks the last strobe cycle; read data is captured here.
        if (cnt_q == 4'd1) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : rd_aligned;
          bc_d        = 1'b0;
          addr_d      = '0;
          ctrl_d      = '0;
          data_oe_d   = 1'b0;
          data_out_d  = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bc_q        <= 1'b0;
      addr_q      <= '0;
      ctrl_q      <= '0;
      data_oe_q   <= 1'b0;
      data_out_q  <= '0;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bc_q        <= bc_d;
      addr_q      <= addr_d;
      ctrl_q      <= ctrl_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
      we_q        <= we_d;
      size_q      <= size_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.BC        = bc_q;
  assign bus.addr      = addr_q;
  assign bus.ctrl      = ctrl_q;
  assign data          = data_oe_q ? data_out_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bus_master
//  Description : Directed self-checking bench for io_bus_master. A simple
//                responder returns rd_val while RD is asserted; the data net
//                is pulled high so an undriven bus reads all ones. Expected
//                responses are queued at request time and popped on
//                rsp_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] rd_val;
  tri1  [31:0] data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  io_bus_master_if bus ();

  io_bus_master dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  // Responder: drives read data only while the RD strobe is high.
  assign data = bus.ctrl[0] ? rd_val : 32'bz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk1({tag, ":unexpected_rsp"}, bus.rsp_valid, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ":rdata"}, bus.rsp_rdata, e.rdata);
      chk1({tag, ":err"}, bus.rsp_err, e.err);
    end
  endtask

  // One complete transaction from the idle cycle it is issued in.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat,
                        input int exp_rd, input int exp_wr,
                        input logic [31:0] exp_bus);
    int k;
    int rd_n;
    int wr_n;
    bit done;
    logic [31:0] exp_d;
    rd_val = rdv;
    chk1({tag, ":ready"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    k = 0; rd_n = 0; wr_n = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      bus.req_valid = 1'b0;
      if (bus.ctrl[0]) rd_n++;
      if (bus.ctrl[1]) wr_n++;
      if (bus.ctrl[0])                     exp_d = rdv;
      else if (bus.BC && we && !exp_err)   exp_d = exp_bus;
      else                                 exp_d = 32'hFFFF_FFFF;
      chk({tag, ":data_bus"}, data, exp_d);
      if (bus.rsp_valid) begin
        done = 1'b1;
        sb_check(tag);
        chk({tag, ":latency"}, 32'(k), 32'(exp_lat));
      end
    end
    if (!done) chk1({tag, ":timeout"}, bus.rsp_valid, 1'b1);
    chk({tag, ":rd_cycles"}, 32'(rd_n), 32'(exp_rd));
    chk({tag, ":wr_cycles"}, 32'(wr_n), 32'(exp_wr));
    @(negedge clk);
    chk1({tag, ":idle_ready"}, bus.req_ready, 1'b1);
    chk1({tag, ":idle_bc"}, bus.BC, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    rd_val = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk1("rst:req_ready", bus.req_ready, 1'b1);
    chk1("rst:rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst:rsp_err", bus.rsp_err, 1'b0);
    chk("rst:rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("rst:bc", bus.BC, 1'b0);
    chk("rst:addr", bus.addr, 32'h0);
    chk("rst:ctrl", 32'(bus.ctrl), 32'h0);
    chk("rst:data", data, 32'hFFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);

    //      tag        we    sz    addr          wdata         rdv           exp_rdata     err   lat rd wr exp_bus
    do_req("wr_word",  1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        32'h0,        1'b0, 3, 0, 1, 32'hDEAD_BEEF);
    do_req("rd_byte",  1'b0, 2'd0, 32'hFFFF_F062, 32'h0,         32'h00AB_0000, 32'h0000_00AB, 1'b0, 5, 3, 0, 32'h0);
    do_req("rd_unmap", 1'b0, 2'd2, 32'hFFFF_F030, 32'h0,         32'h1111_1111, 32'h0,        1'b1, 2, 0, 0, 32'h0);
    do_req("wr_mis",   1'b1, 2'd1, 32'h0000_0003, 32'h0000_1234, 32'h0,        32'h0,        1'b1, 2, 0, 0, 32'h0);
    do_req("rd_half",  1'b0, 2'd1, 32'hFFFF_F072, 32'h0,         32'hCAFE_0000, 32'h0000_CAFE, 1'b0, 5, 3, 0, 32'h0);
    do_req("rd_ram",   1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 3, 1, 0, 32'h0);
    do_req("wr_byte",  1'b1, 2'd0, 32'hFFFF_F011, 32'h0000_005A, 32'h0,        32'h0,        1'b0, 5, 0, 3, 32'h5A5A_5A5A);
    do_req("rd_size3", 1'b0, 2'd3, 32'h0000_0000, 32'h0,         32'h2222_2222, 32'h0,        1'b1, 2, 0, 0, 32'h0);
    do_req("rd_misw",  1'b0, 2'd2, 32'h0000_0102, 32'h0,         32'h3333_3333, 32'h0,        1'b1, 2, 0, 0, 32'h0);
    do_req("rd_b3",    1'b0, 2'd0, 32'h0000_0007, 32'h0,         32'h1234_5678, 32'h0000_0012, 1'b0, 3, 1, 0, 32'h0);

    // Response data holds while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold:rsp_rdata", bus.rsp_rdata, 32'h0000_0012);
      chk1("hold:rsp_valid", bus.rsp_valid, 1'b0);
    end

    // Reset in the second ACCESS cycle of a device read
    rd_val = 32'h5555_AAAA;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'hFFFF_F000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk1("abort:rd_access1", bus.ctrl[0], 1'b1);
    @(negedge clk);
    chk1("abort:rd_access2", bus.ctrl[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort:ctrl", 32'(bus.ctrl), 32'h0);
    chk1("abort:bc", bus.BC, 1'b0);
    chk1("abort:rsp_valid", bus.rsp_valid, 1'b0);
    chk1("abort:req_ready", bus.req_ready, 1'b1);
    chk("abort:rsp_rdata", bus.rsp_rdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("abort:no_rsp", bus.rsp_valid, 1'b0);
      chk1("abort:ready_after", bus.req_ready, 1'b1);
    end

    // req_valid held high: RAM word read re-accepted every fourth cycle
    rd_val = 32'h1122_3344;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h0000_0010;
    chk1("b2b:ready0", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    sb_q.push_back('{rdata: 32'h1122_3344, err: 1'b0});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk1("b2b:ready", bus.req_ready, (k % 4) == 0);
      chk1("b2b:bc", bus.BC, ((k % 4) == 1) || ((k % 4) == 2));
      chk1("b2b:rsp_valid", bus.rsp_valid, (k % 4) == 3);
      if (bus.rsp_valid) sb_check("b2b");
      if (k == 12) bus.req_valid = 1'b0;
      else if ((k % 4) == 0) sb_q.push_back('{rdata: 32'h1122_3344, err: 1'b0});
    end
    repeat (6) begin
      @(negedge clk);
      chk1("b2b:quiet", bus.rsp_valid, 1'b0);
    end
    chk("sb_leftover", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
